edge_mem_resp: RTL and testbench

Word-addressed memory responder that services the edge-detection accelerator's memory requests. Read data returns on `dataR` after a fixed, parameterised latency. Writes commit in one cycle. A side load/dump port lets the host or testbench preload the input image and read back results. The block sits between the accelerator and the image storage, in both the top-level and the bench.

---
 rtl/edge_mem_resp.sv | 107 ++++++++++
 tb/tb_edge_mem_resp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_mem_resp.sv
// Word-addressed memory responder for the edge-detection accelerator.
// The accelerator port has a pipelined fixed read latency; a lower-priority side port handles preload and dump.
module edge_mem_resp #(
  parameter int DEPTH  = 50688,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [31:0] dataW,
  input  logic        en,
  input  logic        we,
  output logic [31:0] dataR,
  output logic        rvalid,
  input  logic        ld_en,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_drop,
  output logic        oob,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic          acc_rd, acc_wr, acc_in;
  logic          ld_go, ld_in;
  logic [AW-1:0] acc_idx, ld_idx;

  logic [31:0]       pipe_d [RD_LAT];
  logic [RD_LAT-1:0] pipe_v;

  assign acc_rd  = en & ~we;
  assign acc_wr  = en & we;
  assign ld_go   = ld_en & ~en;
  assign acc_in  = {1'b0, addr} < DEPTH_L;
  assign ld_in   = {1'b0, ld_addr} < DEPTH_L;
  assign acc_idx = addr[AW-1:0];
  assign ld_idx  = ld_addr[AW-1:0];

  // Array is not reset; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && acc_wr && acc_in) begin
      mem[acc_idx] <= dataW;
    end else if (reset && ld_go && ld_we && ld_in) begin
      mem[ld_idx] <= ld_wdata;
    end
  end

  // Stage 0 samples the array at the request edge; the rest only delay.
  // Data registers load only behind a valid so dataR holds between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= '0;
      end
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= acc_rd;
      if (acc_rd) begin
        pipe_d[0] <= acc_in ? mem[acc_idx] : '0;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign dataR  = pipe_d[RD_LAT-1];
  assign rvalid = pipe_v[RD_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_rdata <= '0;
      ld_drop  <= 1'b0;
      oob      <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (acc_rd) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (acc_wr) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
      if (ld_en && en) begin
        ld_drop <= 1'b1;
      end
      // A dropped side request never flags out-of-range.
      if ((en && !acc_in) || (ld_go && !ld_in)) begin
        oob <= 1'b1;
      end
      if (ld_go && !ld_we) begin
        ld_rdata <= ld_in ? mem[ld_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_edge_mem_resp.sv
// Bench for edge_mem_resp: three instances (RD_LAT 1..3) share one stimulus stream;
// a reference model queues expected read responses per instance and checks every cycle.
module tb_edge_mem_resp;

  localparam int DEPTH = 50688;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] dataW;
  logic        en, we;
  logic        ld_en, ld_we;
  logic [15:0] ld_addr;
  logic [31:0] ld_wdata;

  logic [31:0] dataR_a    [3];
  logic        rvalid_a   [3];
  logic [31:0] ld_rdata_a [3];
  logic        ld_drop_a  [3];
  logic        oob_a      [3];
  logic [31:0] rd_cnt_a   [3];
  logic [31:0] wr_cnt_a   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    edge_mem_resp #(.DEPTH(DEPTH), .RD_LAT(g + 1)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .dataW    (dataW),
      .en       (en),
      .we       (we),
      .dataR    (dataR_a[g]),
      .rvalid   (rvalid_a[g]),
      .ld_en    (ld_en),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_wdata (ld_wdata),
      .ld_rdata (ld_rdata_a[g]),
      .ld_drop  (ld_drop_a[g]),
      .oob      (oob_a[g]),
      .rd_cnt   (rd_cnt_a[g]),
      .wr_cnt   (wr_cnt_a[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  int          cyc = 0;
  logic [31:0] m_mem [int];
  logic [31:0] m_ld_rdata = '0;
  logic [31:0] m_rd_cnt   = '0;
  logic [31:0] m_wr_cnt   = '0;
  logic        m_drop     = 1'b0;
  logic        m_oob      = 1'b0;
  logic [31:0] q_data  [3][$];
  int          q_due   [3][$];
  logic [31:0] last_dr [3] = '{default: '0};

  function automatic bit in_rng(input logic [15:0] a);
    return int'(a) < DEPTH;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ld_rdata = '0;
      m_rd_cnt   = '0;
      m_wr_cnt   = '0;
      m_drop     = 1'b0;
      m_oob      = 1'b0;
      for (int g = 0; g < 3; g++) begin
        q_data[g].delete();
        q_due[g].delete();
        last_dr[g] = '0;
      end
    end else begin
      cyc = cyc + 1;
      if (en && !we) begin
        for (int g = 0; g < 3; g++) begin
          q_data[g].push_back(in_rng(addr) ? m_mem[int'(addr)] : 32'h0);
          q_due[g].push_back(cyc + g);
        end
      end
      if (en) begin
        if (we) m_wr_cnt = m_wr_cnt + 32'd1;
        else    m_rd_cnt = m_rd_cnt + 32'd1;
        if (!in_rng(addr)) m_oob = 1'b1;
      end
      if (ld_en && en) m_drop = 1'b1;
      if (ld_en && !en) begin
        if (!in_rng(ld_addr)) m_oob = 1'b1;
        if (!ld_we) m_ld_rdata = in_rng(ld_addr) ? m_mem[int'(ld_addr)] : 32'h0;
      end
      if (en && we && in_rng(addr))
        m_mem[int'(addr)] = dataW;
      else if (ld_en && !en && ld_we && in_rng(ld_addr))
        m_mem[int'(ld_addr)] = ld_wdata;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      logic exp_v;
      exp_v = (q_due[g].size() > 0) && (q_due[g][0] == cyc);
      check_val($sformatf("rvalid_L%0d", g + 1), 32'(rvalid_a[g]), 32'(exp_v));
      if (exp_v) begin
        last_dr[g] = q_data[g].pop_front();
        void'(q_due[g].pop_front());
      end
      while (q_due[g].size() > 0 && q_due[g][0] < cyc) begin
        void'(q_data[g].pop_front());
        void'(q_due[g].pop_front());
      end
      check_val($sformatf("dataR_L%0d", g + 1),    dataR_a[g],          last_dr[g]);
      check_val($sformatf("ld_rdata_L%0d", g + 1), ld_rdata_a[g],       m_ld_rdata);
      check_val($sformatf("ld_drop_L%0d", g + 1),  32'(ld_drop_a[g]),   32'(m_drop));
      check_val($sformatf("oob_L%0d", g + 1),      32'(oob_a[g]),       32'(m_oob));
      check_val($sformatf("rd_cnt_L%0d", g + 1),   rd_cnt_a[g],         m_rd_cnt);
      check_val($sformatf("wr_cnt_L%0d", g + 1),   wr_cnt_a[g],         m_wr_cnt);
    end
  end

  task automatic drive(input logic e, input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic le, input logic lw, input logic [15:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    en = e; we = w; addr = a; dataW = d;
    ld_en = le; ld_we = lw; ld_addr = la; ld_wdata = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; we = 1'b0; addr = '0; dataW = '0;
    ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Preload through the side port
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'(i), 32'hA000_0000 + 32'(i));
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'd5, 32'h1122_3344);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'(DEPTH - 1), 32'h5A5A_5A5A);
    idle(1);

    // Single read of the preloaded word
    drive(1'b1, 1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    idle(4);

    // Back-to-back streaming reads
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'(i), 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    idle(4);

    // Side-port dump read
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'd5, 32'h0);
    idle(1);

    // Accelerator write collides with side read: side request dropped
    drive(1'b1, 1'b1, 16'd9, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'd9, 32'h0);
    drive(1'b1, 1'b0, 16'd9, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    idle(4);

    // Out of range, then the boundary locations
    drive(1'b1, 1'b1, 16'(DEPTH), 32'hDEAD_DEAD, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 16'(DEPTH), 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 16'(DEPTH - 1), 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    idle(4);

    // Random mixed traffic on both ports
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a, la;
      a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
      la = ($urandom_range(0, 7) == 0) ? 16'hFFF0 : 16'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), la, $urandom);
    end
    idle(4);

    // Write counter wrap
    @(posedge clk);
    #1;
    force g_dut[0].u_dut.wr_cnt = 32'hFFFF_FFFF;
    force g_dut[1].u_dut.wr_cnt = 32'hFFFF_FFFF;
    force g_dut[2].u_dut.wr_cnt = 32'hFFFF_FFFF;
    m_wr_cnt = 32'hFFFF_FFFF;
    #1;
    release g_dut[0].u_dut.wr_cnt;
    release g_dut[1].u_dut.wr_cnt;
    release g_dut[2].u_dut.wr_cnt;
    en = 1'b1; we = 1'b1; addr = 16'd20; dataW = 32'h0BAD_F00D;
    ld_en = 1'b0;
    idle(3);

    // Reset in the middle of a read stream
    drive(1'b1, 1'b0, 16'd1, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 16'd2, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 16'd3, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(posedge clk);
    #1;
    en = 1'b0; reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(6);

    // Normal operation after reset
    drive(1'b1, 1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 16'(DEPTH - 1), 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
